// File: rtl/lsu_queue_pkg.sv
// Shared constants and the queue entry type for the load/store queue.
package lsu_queue_pkg;

  localparam int ROB_ENTRIES = 32;
  localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);
  localparam int LSQ_ENTRIES = 8;
  localparam int LSQ_PTR_W   = $clog2(LSQ_ENTRIES);
  localparam int LSQ_CNT_W   = LSQ_PTR_W + 1;

  typedef struct packed {
    logic                 wr_rd;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } lsq_entry_t;

endpackage

// File: rtl/lsu_queue_flush_scan.sv
// Priority scan from head: how many entries survive a flush (up to and including
// the cmt_cnt-th store) and the tail index just past them.
module lsq_flush_scan #(
  parameter  int ENTRIES = 8,
  localparam int PTR_W   = $clog2(ENTRIES),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic [PTR_W-1:0]   head_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic [CNT_W-1:0]   cmt_cnt_i,
  input  logic [ENTRIES-1:0] wr_rd_i,
  output logic [CNT_W-1:0]   retain_o,
  output logic [PTR_W-1:0]   tail_o
);

  logic [CNT_W-1:0] seen_s;
  logic [CNT_W-1:0] retain_s;
  logic             found_s;
  logic [PTR_W-1:0] idx_s;

  // Walk occupied slots oldest-first; a zero commit count never matches, so nothing is kept.
  always_comb begin
    seen_s   = {CNT_W{1'b0}};
    retain_s = {CNT_W{1'b0}};
    found_s  = 1'b0;
    idx_s    = head_i;
    for (int i = 0; i < ENTRIES; i++) begin
      idx_s = head_i + PTR_W'(i);
      if ((CNT_W'(i) < count_i) && !found_s && wr_rd_i[idx_s]) begin
        seen_s = seen_s + CNT_W'(1);
        if (seen_s == cmt_cnt_i) begin
          found_s  = 1'b1;
          retain_s = CNT_W'(i + 1);
        end else begin
          found_s  = found_s;
        end
      end else begin
        seen_s = seen_s;
      end
    end
    retain_o = retain_s;
    tail_o   = head_i + retain_s[PTR_W-1:0];
  end

endmodule

// File: rtl/lsu_queue.sv
// In-order load/store queue feeding cache_controller; stores wait for ROB commit.
// Optional same-cycle load bypass on an empty queue: define LSQ_BYPASS_EN.
module lsu_queue #(
  parameter int LSQ_ENTRIES = lsu_queue_pkg::LSQ_ENTRIES
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                agu_vld_i,
  output logic                                agu_rdy_o,
  input  logic                                agu_wr_rd_i,
  input  logic [31:0]                         agu_addr_i,
  input  logic [31:0]                         agu_data_i,
  input  logic [lsu_queue_pkg::ROB_IDX_W-1:0] agu_rob_idx_i,
  input  logic                                rob_st_cmt_i,
  input  logic                                cache_busy_i,
  output logic                                lsu_req_vld_o,
  output logic                                lsu_req_wr_rd_o,
  output logic [31:0]                         lsu_req_addr_o,
  output logic [31:0]                         lsu_req_data_o,
  output logic [lsu_queue_pkg::ROB_IDX_W-1:0] lsu_req_rob_idx_o,
  output logic                                lsq_full_o,
  output logic                                lsq_empty_o
);

  import lsu_queue_pkg::*;

  localparam int PTR_W = $clog2(LSQ_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSQ_ENTRIES);

  logic [PTR_W-1:0]       head_r, tail_r;
  logic [CNT_W-1:0]       count_r, cmt_cnt_r;
  logic [LSQ_ENTRIES-1:0] valid_r;
  lsq_entry_t             mem_r [LSQ_ENTRIES];

  lsq_entry_t             head_ent_s, agu_ent_s, req_s;
  logic                   full_s, agu_rdy_s, head_vld_s, fire_s, enq_s, byp_s;
  logic [PTR_W-1:0]       head_post_s, tail_n_s, scan_tail_s, off_s;
  logic [CNT_W-1:0]       count_post_s, cmt_post_s, count_n_s, retain_s;
  logic [LSQ_ENTRIES-1:0] valid_n_s, wr_vec_s;

  assign head_ent_s = mem_r[head_r];
  assign agu_ent_s  = '{wr_rd: agu_wr_rd_i, addr: agu_addr_i, data: agu_data_i, rob_idx: agu_rob_idx_i};
  assign full_s     = (count_r == FULL_CNT);
  assign agu_rdy_s  = rst_i && !full_s && !flush_i;
  assign head_vld_s = rst_i && (count_r != {CNT_W{1'b0}}) && valid_r[head_r] &&
                      (!head_ent_s.wr_rd || (cmt_cnt_r != {CNT_W{1'b0}}));
  assign fire_s     = head_vld_s && !cache_busy_i;

`ifdef LSQ_BYPASS_EN
  assign byp_s = rst_i && (count_r == {CNT_W{1'b0}}) && agu_vld_i && !agu_wr_rd_i &&
                 !cache_busy_i && !flush_i;
`else
  assign byp_s = 1'b0;
`endif

  // A bypassed load goes straight to the cache and never occupies a slot.
  assign enq_s = agu_vld_i && agu_rdy_s && !byp_s;

  // Store-direction bits of every slot, for the flush scan.
  always_comb begin
    wr_vec_s = {LSQ_ENTRIES{1'b0}};
    for (int j = 0; j < LSQ_ENTRIES; j++) begin
      wr_vec_s[j] = mem_r[j].wr_rd;
    end
  end

  // Queue state after this cycle's issue, which the flush boundary is measured from.
  always_comb begin
    head_post_s  = head_r;
    count_post_s = count_r;
    cmt_post_s   = cmt_cnt_r;
    if (fire_s) begin
      head_post_s  = head_r + PTR_W'(1);
      count_post_s = count_r - CNT_W'(1);
      if (head_ent_s.wr_rd) begin
        cmt_post_s = cmt_cnt_r - CNT_W'(1);
      end else begin
        cmt_post_s = cmt_cnt_r;
      end
    end else begin
      head_post_s = head_r;
    end
    if (rob_st_cmt_i) begin
      cmt_post_s = cmt_post_s + CNT_W'(1);
    end else begin
      cmt_post_s = cmt_post_s;
    end
  end

  lsq_flush_scan #(.ENTRIES(LSQ_ENTRIES)) u_flush_scan (
    .head_i    (head_post_s),
    .count_i   (count_post_s),
    .cmt_cnt_i (cmt_post_s),
    .wr_rd_i   (wr_vec_s),
    .retain_o  (retain_s),
    .tail_o    (scan_tail_s)
  );

  // Next tail, occupancy and slot-valid bits, either after a flush or a normal enqueue.
  always_comb begin
    valid_n_s = valid_r;
    off_s     = {PTR_W{1'b0}};
    if (fire_s) begin
      valid_n_s[head_r] = 1'b0;
    end else begin
      valid_n_s = valid_r;
    end
    if (flush_i) begin
      count_n_s = retain_s;
      tail_n_s  = scan_tail_s;
      for (int j = 0; j < LSQ_ENTRIES; j++) begin
        off_s        = PTR_W'(j) - head_post_s;
        valid_n_s[j] = ({1'b0, off_s} < retain_s);
      end
    end else if (enq_s) begin
      count_n_s         = count_post_s + CNT_W'(1);
      tail_n_s          = tail_r + PTR_W'(1);
      valid_n_s[tail_r] = 1'b1;
    end else begin
      count_n_s = count_post_s;
      tail_n_s  = tail_r;
    end
  end

  // Pointer, counter and valid-bit registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      cmt_cnt_r <= {CNT_W{1'b0}};
      valid_r   <= {LSQ_ENTRIES{1'b0}};
    end else begin
      head_r    <= head_post_s;
      tail_r    <= tail_n_s;
      count_r   <= count_n_s;
      cmt_cnt_r <= cmt_post_s;
      valid_r   <= valid_n_s;
    end
  end

  // Entry payload storage; contents are only trusted through the valid bits.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_r[tail_r] <= agu_ent_s;
    end
  end

  // Request mux: bypassed AGU load, head entry, or all-zero when idle.
  always_comb begin
    if (byp_s) begin
      req_s = agu_ent_s;
    end else if (head_vld_s) begin
      req_s = head_ent_s;
    end else begin
      req_s = '0;
    end
  end

  assign agu_rdy_o         = agu_rdy_s;
  assign lsu_req_vld_o     = head_vld_s || byp_s;
  assign lsu_req_wr_rd_o   = req_s.wr_rd;
  assign lsu_req_addr_o    = req_s.addr;
  assign lsu_req_data_o    = req_s.data;
  assign lsu_req_rob_idx_o = req_s.rob_idx;
  assign lsq_full_o        = full_s;
  assign lsq_empty_o       = (count_r == {CNT_W{1'b0}});

endmodule

// File: tb/tb_lsu_queue.sv
// Self-checking bench for lsu_queue: directed scenarios then random traffic
// against a queue-based reference model.
module tb_lsu_queue;
  import lsu_queue_pkg::*;

  localparam int N = LSQ_ENTRIES;

  logic                 clk_i = 1'b0;
  logic                 rst_i, flush_i, agu_vld_i, agu_rdy_o, agu_wr_rd_i;
  logic [31:0]          agu_addr_i, agu_data_i;
  logic [ROB_IDX_W-1:0] agu_rob_idx_i;
  logic                 rob_st_cmt_i, cache_busy_i;
  logic                 lsu_req_vld_o, lsu_req_wr_rd_o;
  logic [31:0]          lsu_req_addr_o, lsu_req_data_o;
  logic [ROB_IDX_W-1:0] lsu_req_rob_idx_o;
  logic                 lsq_full_o, lsq_empty_o;

  always #5 clk_i = ~clk_i;

  lsu_queue dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .agu_vld_i(agu_vld_i), .agu_rdy_o(agu_rdy_o), .agu_wr_rd_i(agu_wr_rd_i),
    .agu_addr_i(agu_addr_i), .agu_data_i(agu_data_i), .agu_rob_idx_i(agu_rob_idx_i),
    .rob_st_cmt_i(rob_st_cmt_i), .cache_busy_i(cache_busy_i),
    .lsu_req_vld_o(lsu_req_vld_o), .lsu_req_wr_rd_o(lsu_req_wr_rd_o),
    .lsu_req_addr_o(lsu_req_addr_o), .lsu_req_data_o(lsu_req_data_o),
    .lsu_req_rob_idx_o(lsu_req_rob_idx_o),
    .lsq_full_o(lsq_full_o), .lsq_empty_o(lsq_empty_o)
  );

  typedef struct {
    bit                   wr;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [ROB_IDX_W-1:0] rob;
  } ment_t;

  ment_t q[$];
  int    mcmt;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int uncommitted_stores();
    int n = 0;
    foreach (q[i]) if (q[i].wr) n++;
    return n - mcmt;
  endfunction

  // One clock: drive, check at negedge against the model, advance the model.
  task automatic cycle(input bit rst, input bit flush, input bit vld, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [ROB_IDX_W-1:0] rob, input bit cmt, input bit busy,
                       output bit accepted);
    bit    byp, e_rdy, head_ok, fire;
    ment_t e;
    int    keep, seen;
    rst_i = rst; flush_i = flush; agu_vld_i = vld; agu_wr_rd_i = wr;
    agu_addr_i = addr; agu_data_i = data; agu_rob_idx_i = rob;
    rob_st_cmt_i = cmt; cache_busy_i = busy;
    @(negedge clk_i);
    byp = 1'b0;
`ifdef LSQ_BYPASS_EN
    byp = rst && q.size() == 0 && vld && !wr && !busy && !flush;
`endif
    e_rdy   = rst && q.size() < N && !flush;
    head_ok = rst && q.size() > 0 && (!q[0].wr || mcmt > 0);
    e = '{wr: 1'b0, addr: 32'h0, data: 32'h0, rob: '0};
    if (byp) e = '{wr: wr, addr: addr, data: data, rob: rob};
    else if (head_ok) e = q[0];
    check_val("agu_rdy", agu_rdy_o, e_rdy);
    check_val("req_vld", lsu_req_vld_o, head_ok || byp);
    check_val("req_wr_rd", lsu_req_wr_rd_o, e.wr);
    check_val("req_addr", lsu_req_addr_o, e.addr);
    check_val("req_data", lsu_req_data_o, e.data);
    check_val("req_rob_idx", lsu_req_rob_idx_o, e.rob);
    if (rst) begin
      check_val("full", lsq_full_o, q.size() == N);
      check_val("empty", lsq_empty_o, q.size() == 0);
    end
    accepted = vld && e_rdy && !byp;
    if (!rst) begin
      q.delete();
      mcmt = 0;
    end else begin
      fire = head_ok && !busy;
      if (fire) begin
        if (q[0].wr) mcmt--;
        void'(q.pop_front());
      end
      if (cmt) mcmt++;
      if (flush) begin
        keep = 0; seen = 0;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].wr) begin
            seen++;
            if (mcmt > 0 && seen == mcmt && keep == 0) keep = i + 1;
          end
        end
        while (q.size() > keep) void'(q.pop_back());
      end else if (accepted) begin
        q.push_back('{wr: wr, addr: addr, data: data, rob: rob});
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input bit busy, input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 32'h0, 32'h0, '0, 0, busy, acc);
  endtask

  initial begin
    bit acc;
    int next;
    mcmt = 0;
    @(posedge clk_i); #1;
    // reset, with an AGU op present to show it is refused
    cycle(0, 0, 1, 0, 32'h44, 32'h0, '0, 0, 0, acc);
    cycle(0, 0, 1, 0, 32'h44, 32'h0, '0, 0, 0, acc);
    check_val("rst_full", lsq_full_o, 1'b0);
    check_val("rst_empty", lsq_empty_o, 1'b1);

    // single load
    cycle(1, 0, 1, 0, 32'h100, 32'h0, ROB_IDX_W'(3), 0, 0, acc);
    idle(0, 2);

    // store held until commit
    cycle(1, 0, 1, 1, 32'h200, 32'hDEADBEEF, ROB_IDX_W'(4), 0, 0, acc);
    idle(0, 5);
    cycle(1, 0, 0, 0, 32'h0, 32'h0, '0, 1, 0, acc);
    idle(0, 2);

    // fill with busy, then stream 20 ops through wrap
    next = 0;
    while (next < N) begin
      cycle(1, 0, 1, 0, 32'h1000 + 32'(next * 4), 32'h0, ROB_IDX_W'(next), 0, 1, acc);
      if (acc) next++;
    end
    cycle(1, 0, 1, 0, 32'h1000 + 32'(next * 4), 32'h0, ROB_IDX_W'(next), 0, 1, acc);
    if (acc) next++;
    while (next < 20) begin
      cycle(1, 0, 1, 0, 32'h1000 + 32'(next * 4), 32'h0, ROB_IDX_W'(next), 0, 0, acc);
      if (acc) next++;
    end
    idle(0, N + 2);

    // flush keeps A and committed B, drops C and uncommitted D
    cycle(1, 0, 1, 0, 32'hA0, 32'h0, ROB_IDX_W'(1), 0, 1, acc);
    cycle(1, 0, 1, 1, 32'hB0, 32'hBBBB, ROB_IDX_W'(2), 0, 1, acc);
    cycle(1, 0, 1, 0, 32'hC0, 32'h0, ROB_IDX_W'(3), 1, 1, acc);
    cycle(1, 0, 1, 1, 32'hD0, 32'hDDDD, ROB_IDX_W'(4), 0, 1, acc);
    cycle(1, 1, 1, 0, 32'hE0, 32'h0, ROB_IDX_W'(5), 0, 1, acc);
    idle(0, 4);

    // commit coincident with a committed store issuing
    cycle(1, 0, 1, 1, 32'h510, 32'h1111, ROB_IDX_W'(6), 0, 1, acc);
    cycle(1, 0, 1, 1, 32'h520, 32'h2222, ROB_IDX_W'(7), 0, 1, acc);
    cycle(1, 0, 0, 0, 32'h0, 32'h0, '0, 1, 1, acc);
    cycle(1, 0, 0, 0, 32'h0, 32'h0, '0, 1, 0, acc);
    idle(0, 3);

    // load on empty queue (same-cycle with bypass, next cycle without)
    cycle(1, 0, 1, 0, 32'h300, 32'h0, ROB_IDX_W'(9), 0, 0, acc);
    idle(0, 2);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      bit r_rst, r_fl, r_cmt;
      r_rst = ($urandom_range(499) != 0);
      r_fl  = ($urandom_range(24) == 0);
      r_cmt = !r_fl && uncommitted_stores() > 0 && ($urandom_range(2) == 0);
      cycle(r_rst, r_fl, $urandom_range(9) < 6, $urandom_range(1) == 1, $urandom,
            $urandom, ROB_IDX_W'($urandom), r_cmt, $urandom_range(9) < 3, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
